// File: rtl/big_memory_c_loader.sv
// Fills the eight A/B fragment lanes of the C search-window memory from a 32-bit word stream.
// Latency: one cycle from an accepted word to its registered one-hot lane strobe.
// Backpressure: InReady only in LOAD; a word offered without InReady stays with the source.
module big_memory_c_loader #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [31:0]      BaseAddress,
  input  logic [CNT_W-1:0] RowCount,
  input  logic [31:0]      InData,
  input  logic             InValid,
  output logic             InReady,
  output logic [31:0]      WrAddress,
  output logic [31:0]      WrData,
  output logic [15:0]      WrEnable,
  output logic             cMemWrite,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      base;
  logic [CNT_W-1:0] last_row;
  logic [CNT_W-1:0] row;
  logic [3:0]       lane;
  logic             accept;
  logic             last_word;
  logic             start_load;

  assign accept     = InValid && InReady;
  assign last_word  = (lane == 4'd15) && (row == last_row);
  assign start_load = (state == IDLE) && Start && (RowCount != '0);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    InReady   = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          // A zero-row request completes without ever opening the stream.
          state_nxt = (RowCount != '0) ? LOAD : DONE;
        end
      end
      LOAD: begin
        InReady = 1'b1;
        Busy    = 1'b1;
        if (accept && last_word) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        Busy      = 1'b1;
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      base      <= '0;
      last_row  <= '0;
      row       <= '0;
      lane      <= '0;
      WrAddress <= '0;
      WrData    <= '0;
      WrEnable  <= '0;
    end else begin
      WrEnable <= '0;
      if (start_load) begin
        base     <= BaseAddress;
        last_row <= RowCount - CNT_W'(1);
        row      <= '0;
        lane     <= '0;
      end
      if (accept) begin
        WrData    <= InData;
        WrEnable  <= 16'(1) << lane;
        WrAddress <= base + 32'(row);
        // Lane order is frag0 A, frag0 B, ..., frag7 B; the 4-bit counter wraps into the next row.
        lane      <= lane + 4'd1;
        if (lane == 4'd15) begin
          row <= row + CNT_W'(1);
        end
      end
    end
  end

  assign cMemWrite = |WrEnable;

  a_strobe_onehot: assert property (@(posedge Clk) disable iff (Reset) $onehot0(WrEnable));

endmodule

// File: tb/tb_big_memory_c_loader.sv
// Randomized scoreboard bench for big_memory_c_loader: expected writes are derived from
// word index -> (row, lane) and compared by an independent strobe monitor.
module tb_big_memory_c_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_address;
  logic [15:0] row_count;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] wr_address;
  logic [31:0] wr_data;
  logic [15:0] wr_enable;
  logic        cmem_write;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  big_memory_c_loader #(.CNT_W(16)) dut (
    .Clk         (clk),
    .Reset       (reset),
    .Start       (start),
    .BaseAddress (base_address),
    .RowCount    (row_count),
    .InData      (in_data),
    .InValid     (in_valid),
    .InReady     (in_ready),
    .WrAddress   (wr_address),
    .WrData      (wr_data),
    .WrEnable    (wr_enable),
    .cMemWrite   (cmem_write),
    .Busy        (busy),
    .Done        (done)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [15:0] en;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  strobes  = 0;
  bit  mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_inready"}, 32'(in_ready), 0);
    chk({tag, "_wraddr"}, wr_address, 0);
    chk({tag, "_wrdata"}, wr_data, 0);
    chk({tag, "_wren"}, 32'(wr_enable), 0);
    chk({tag, "_cmemwrite"}, 32'(cmem_write), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  // Monitor: every visible strobe must match the oldest outstanding expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("cmemwrite_is_or", 32'(cmem_write), 32'(|wr_enable));
        if (wr_enable != 16'h0) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe: got en=%h addr=%h expected no write", wr_enable, wr_address);
          end else begin
            e = exp_q.pop_front();
            chk("strobe_en", 32'(wr_enable), 32'(e.en));
            chk("strobe_addr", wr_address, e.addr);
            chk("strobe_data", wr_data, e.data);
            strobes++;
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge where the FSM state reflects the Start.
  task automatic do_start(input logic [31:0] b, input logic [15:0] n);
    start        = 1'b1;
    base_address = b;
    row_count    = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input logic [31:0] b, input int n, input int pct, input bit seq_data,
                          input int poke_idx, input int abort_after);
    int          acc;
    int          strobes0;
    int          budget;
    bit          acc_now;
    logic [31:0] word;
    acc = 0;
    do_start(b, 16'(n));
    chk("busy_after_start", 32'(busy), 1);
    chk("inready_after_start", 32'(in_ready), 1);
    strobes0 = strobes;
    for (int idx = 0; idx < 16 * n; idx++) begin
      word    = seq_data ? (32'h100 + 32'(idx)) : $urandom;
      budget  = 0;
      acc_now = 1'b0;
      while (!acc_now) begin
        in_data  = word;
        in_valid = (pct >= 100) || ($urandom_range(99) < pct);
        start    = (idx == poke_idx) && (budget == 0);
        if (start) begin
          base_address = 32'hDEAD0000;
          row_count    = 16'd7;
        end
        if (in_valid && in_ready) begin
          acc_now = 1'b1;
          exp_q.push_back('{addr: b + 32'(idx / 16), data: word, en: 16'(1) << (idx % 16)});
        end
        @(negedge clk);
        budget++;
        if (!acc_now && budget > 200) begin
          checks++;
          failures++;
          $display("FAIL accept_timeout: got no accept for word %0d expected accept within 200 cycles", idx);
          in_valid = 1'b0;
          start    = 1'b0;
          return;
        end
      end
      acc++;
      if (acc == abort_after) begin
        in_valid = 1'b0;
        start    = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("done_with_last_strobe", 32'(done), 1);
    chk("inready_in_done", 32'(in_ready), 0);
    chk("busy_in_done", 32'(busy), 1);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
    chk("busy_drop", 32'(busy), 0);
    chk("strobe_count", 32'(strobes - strobes0), 32'(16 * n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    base_address = '0;
    row_count    = '0;
    in_data      = '0;
    in_valid     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Single row, sequential data, no gaps.
    run_load(32'h40, 1, 100, 1'b1, -1, -1);
    // Three rows with random InValid gaps.
    run_load($urandom, 3, 60, 1'b0, -1, -1);
    // Address wraps from 0xFFFFFFFF to 0 on the second row.
    run_load(32'hFFFF_FFFF, 2, 80, 1'b0, -1, -1);

    // Zero row count: Done next cycle, stream never opens.
    do_start(32'h55, 16'd0);
    chk("zero_done", 32'(done), 1);
    chk("zero_busy", 32'(busy), 1);
    chk("zero_inready", 32'(in_ready), 0);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = $urandom;
      @(negedge clk);
      chk("zero_inready_after", 32'(in_ready), 0);
      chk("zero_wren", 32'(wr_enable), 0);
      if (i == 0) begin
        chk("zero_done_end", 32'(done), 0);
        chk("zero_idle", 32'(busy), 0);
      end
    end
    in_valid = 1'b0;

    // Start pulsed on the 5th word must not disturb the active load.
    run_load(32'h200, 1, 100, 1'b0, 4, -1);

    // Reset after the 20th accepted word of a 2-row load.
    run_load(32'h300, 2, 70, 1'b0, -1, 20);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("abort");
    chk("abort_queue_empty", 32'(exp_q.size()), 0);
    reset = 1'b0;
    run_load(32'h10, 1, 100, 1'b0, -1, -1);

    @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
